// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: grants one command per
// cycle, tracks the outstanding read and steers its data back to the issuing port.
module dmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
    $fatal(1, "dmem_arbiter: RD_LAT must be in 1..7");
  end

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        lat_cnt, lat_cnt_nxt;
  logic              owner, owner_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic              rd_done, gnt, winner, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;

  // The completion cycle is also an arbitration cycle, so reads can be chained
  // back to back without a bubble.
  always_comb begin
    rd_done = (state == RD_WAIT) && (lat_cnt == 3'(RD_LAT));
    if (m0_req_i && m1_req_i) winner = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
    else                      winner = m1_req_i;
    gnt       = rst_ni && (m0_req_i || m1_req_i) && ((state == IDLE) || rd_done);
    win_we    = winner ? m1_we_i    : m0_we_i;
    win_addr  = winner ? m1_addr_i  : m0_addr_i;
    win_wdata = winner ? m1_wdata_i : m0_wdata_i;
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    owner_nxt   = owner;
    rr_ptr_nxt  = rr_ptr;
    if (state == RD_WAIT) lat_cnt_nxt = lat_cnt + 3'd1;
    if (rd_done) begin
      state_nxt   = IDLE;
      lat_cnt_nxt = '0;
    end
    if (gnt) begin
      rr_ptr_nxt = ~winner;
      if (!win_we) begin
        state_nxt   = RD_WAIT;
        lat_cnt_nxt = 3'd1;
        owner_nxt   = winner;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      lat_cnt <= '0;
      owner   <= 1'b0;
      rr_ptr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  assign m0_gnt_o    = gnt & ~winner;
  assign m1_gnt_o    = gnt &  winner;
  assign mem_en_o    = gnt;
  assign mem_we_o    = gnt & win_we;
  assign mem_addr_o  = gnt ? win_addr  : '0;
  assign mem_wdata_o = gnt ? win_wdata : '0;

  assign m0_rvalid_o = rd_done & ~owner;
  assign m1_rvalid_o = rd_done &  owner;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule
